fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter PC_RESET, default 8'h00, meaning the PC value loaded on reset.
REQ-002 SHALL have parameter IMEM_DEPTH, default 32, meaning the instruction-memory word count; the PC wraps modulo this value.
REQ-003 SHALL have port clk  input  1  rising-edge clock; one clock; all state updates on posedge clk.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port pc  output  8  fetch address driven to instruction memory.
REQ-006 SHALL have port instr_code  input  8  combinational instruction-memory read data for pc.
REQ-007 SHALL have port stall  input  1  hold PC and IF/ID register.
REQ-008 SHALL have port flush  input  1  squash the IF/ID contents (bubble).
REQ-009 SHALL have port redirect_valid  input  1  control-transfer request from a later stage.
REQ-010 SHALL have port redirect_pc  input  8  target PC for redirect_valid.
REQ-011 SHALL have port ifid_instr  output  8  registered instruction to decode.
REQ-012 SHALL have port ifid_pc  output  8  registered (PC+1) mod IMEM_DEPTH of the latched instruction.
REQ-013 SHALL have port ifid_valid  output  1  ifid_instr holds a real instruction.

Function
REQ-014 SHALL evaluate next-PC priority per posedge: reset, then redirect_valid, then stall, then early jump (REQ-017), then sequential.
REQ-015 SHALL compute sequential next PC as (pc+1) mod IMEM_DEPTH, so IMEM_DEPTH-1 wraps to 0.
REQ-016 SHALL load redirect_pc mod IMEM_DEPTH when redirect_valid=1, even if stall=1.
REQ-017 SHALL treat instr_code[7:6]==2'b11 as a jump and, when enabled (REQ-027), set next PC to {2'b00,instr_code[5:0]} mod IMEM_DEPTH.
REQ-018 SHALL hold pc, ifid_instr, ifid_pc and ifid_valid unchanged when stall=1, flush=0 and redirect_valid=0.
REQ-019 SHALL, when not stalled and not squashed, latch ifid_instr<=instr_code, ifid_pc<=(pc+1) mod IMEM_DEPTH and ifid_valid<=1; fetch-to-decode latency is 1 cycle.
REQ-020 SHALL squash on flush=1 or redirect_valid=1: ifid_instr<=8'h00, ifid_pc<=8'h00, ifid_valid<=0, regardless of stall.
REQ-021 SHALL, on stall=1 with flush=1 and redirect_valid=0, hold pc and squash IF/ID.
REQ-022 SHALL drive pc directly from the PC register, with no combinational path from any input to pc.

Reset
REQ-023 SHALL, on posedge clk with reset=0, set pc=PC_RESET, ifid_instr=8'h00, ifid_pc=8'h00, ifid_valid=0, overriding all other inputs.
REQ-024 SHALL, on reset asserted mid-operation, discard in-flight state with no partial update that cycle.
REQ-025 SHALL present PC_RESET on pc in the first cycle after reset releases, with ifid_valid=1 one cycle later.

Configuration
REQ-026 SHALL use the macro FETCH_JUMP_PREDECODE_EN to select early jump resolution.
REQ-027 SHALL, with FETCH_JUMP_PREDECODE_EN defined, apply REQ-017 (zero-bubble jump; the jump instruction itself still enters IF/ID).
REQ-028 SHALL, without FETCH_JUMP_PREDECODE_EN, ignore instr_code for next-PC; jumps resolve only via redirect_valid.

Verification
REQ-029 SHALL cover sequential fetch: IMEM 08,41,70,81,0E,4E; release reset -> pc 0,1,2,3,4,5; ifid_instr 08,41,70,81,0E one cycle behind; ifid_pc 01..05.
REQ-030 SHALL cover stall: assert stall 2 cycles at pc=3 -> pc stays 3, ifid_instr stays 70, ifid_valid stays 1; resume -> 81 at the next edge.
REQ-031 SHALL cover redirect over stall: stall=1, redirect_valid=1, redirect_pc=8'h01 -> next pc=1, ifid_valid=0; following edge ifid_instr=41.
REQ-032 SHALL cover wrap: pc=31, no stall -> next pc=0, ifid_pc=8'h00.
REQ-033 SHALL cover early jump: instr_code=8'hC4 at pc=2 -> with macro, next pc=4 and ifid_instr=C4; without macro, next pc=3.
REQ-034 SHALL cover mid-run reset: reset=0 at pc=4 -> next edge pc=PC_RESET, ifid_valid=0, ifid_instr=00.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: PC register and IF/ID pipeline register with redirect, stall, flush and wrap-around.
// Define FETCH_JUMP_PREDECODE_EN to resolve jumps (instr_code[7:6]==2'b11) at fetch with zero bubbles.
module fetch_unit #(
  parameter logic [7:0] PC_RESET   = 8'h00,
  parameter int         IMEM_DEPTH = 32
) (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] pc,
  input  logic [7:0] instr_code,
  input  logic       stall,
  input  logic       flush,
  input  logic       redirect_valid,
  input  logic [7:0] redirect_pc,
  output logic [7:0] ifid_instr,
  output logic [7:0] ifid_pc,
  output logic       ifid_valid
);
  logic [7:0] pc_seq, pc_red, pc_jmp, pc_nxt;
  logic       jump, squash;
  always_comb begin
    pc_seq = 8'(({24'd0, pc} + 32'd1) % IMEM_DEPTH);
    pc_red = 8'({24'd0, redirect_pc} % IMEM_DEPTH);
    pc_jmp = 8'({26'd0, instr_code[5:0]} % IMEM_DEPTH);
`ifdef FETCH_JUMP_PREDECODE_EN
    jump   = instr_code[7:6] == 2'b11;
`else
    jump   = 1'b0;
`endif
    squash = flush | redirect_valid;
    pc_nxt = redirect_valid ? pc_red : stall ? pc : jump ? pc_jmp : pc_seq;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc         <= PC_RESET;
      ifid_instr <= 8'h00;
      ifid_pc    <= 8'h00;
      ifid_valid <= 1'b0;
    end else begin
      pc <= pc_nxt;
      if (squash) begin
        ifid_instr <= 8'h00;
        ifid_pc    <= 8'h00;
        ifid_valid <= 1'b0;
      end else if (!stall) begin
        ifid_instr <= instr_code;
        ifid_pc    <= pc_seq;
        ifid_valid <= 1'b1;
      end
    end
  end
endmodule
